// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared CPU definitions: datapath widths, the default depth
//                of the fetched-instruction buffer and the fetch FSM states.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int ADDR_W      = 32;
  localparam int INST_W      = 32;
  localparam int FETCH_DEPTH = 2;

  // IDLE : ready for a new PC (if the buffer has room)
  // REQ  : request on the memory port, waiting for grant
  // WAIT : granted, waiting for read data
  // DRAIN: granted request was flushed, its response must be swallowed
  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_WAIT  = 2'd2,
    FETCH_DRAIN = 2'd3
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/inst_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fifo
//  Description : Fetched-instruction buffer. Stores {pc, instruction} pairs
//                in order; head entry is presented combinationally.
//  Ports       : clk_i, rst_i       - clock, synchronous active-high reset
//                push, wr_pc,
//                wr_inst            - write one entry at the tail
//                pop                - remove the head entry
//                flush              - empty the buffer (overrides push/pop)
//                full, empty        - occupancy status
//                head_pc, head_inst - head entry contents
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push,
  input  logic [ADDR_W-1:0] wr_pc,
  input  logic [INST_W-1:0] wr_inst,
  input  logic              pop,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] head_pc,
  output logic [INST_W-1:0] head_inst
);

  localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed while count > 0.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      pc_mem[wr_ptr]   <= wr_pc;
      inst_mem[wr_ptr] <= wr_inst;
    end
  end

  assign head_pc   = pc_mem[rd_ptr];
  assign head_inst = inst_mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch
//  Description : Instruction fetch stage. Accepts a PC, issues a single
//                outstanding read to instruction memory and buffers the
//                returned words for decode. A flush discards buffered and
//                in-flight fetches.
//  Ports       : clk_i, rst_i          - clock, synchronous active-high reset
//                pc_i, pc_valid_i,
//                pc_ready_o            - PC handshake from the PC stage
//                imem_req_o,
//                imem_addr_o,
//                imem_gnt_i            - memory request / grant
//                imem_rvalid_i,
//                imem_rdata_i          - memory read response
//                flush_i               - branch taken, drop everything
//                inst_valid_o, inst_o,
//                inst_pc_o,
//                inst_ready_i          - instruction handshake toward decode
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_valid_i,
  output logic              pc_ready_o,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  input  logic              flush_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              inst_ready_i
);

  fetch_state_e      state;
  fetch_state_e      state_next;
  logic [ADDR_W-1:0] pc_q;
  logic              accept;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [ADDR_W-1:0] head_pc;
  logic [INST_W-1:0] head_inst;

  // A new PC is taken only when nothing is in flight, so the buffer can
  // never overflow from the response of an accepted PC.
  assign pc_ready_o   = (state == FETCH_IDLE) && !flush_i && !rst_i && !full;
  assign accept       = pc_valid_i && pc_ready_o;

  assign imem_req_o   = (state == FETCH_REQ) && !rst_i;
  assign imem_addr_o  = rst_i ? '0 : pc_q;

  assign inst_valid_o = !empty && !rst_i;
  assign inst_o       = inst_valid_o ? head_inst : '0;
  assign inst_pc_o    = inst_valid_o ? head_pc   : '0;
  assign pop          = inst_valid_o && inst_ready_i;

  always_comb begin
    state_next = state;
    push       = 1'b0;
    case (state)
      FETCH_IDLE: begin
        if (accept) state_next = FETCH_REQ;
      end
      FETCH_REQ: begin
        // A grant coinciding with flush still launches the read; its data
        // must be swallowed in DRAIN.
        if (imem_gnt_i)   state_next = flush_i ? FETCH_DRAIN : FETCH_WAIT;
        else if (flush_i) state_next = FETCH_IDLE;
      end
      FETCH_WAIT: begin
        if (imem_rvalid_i) begin
          state_next = FETCH_IDLE;
          push       = !flush_i;
        end else if (flush_i) begin
          state_next = FETCH_DRAIN;
        end
      end
      FETCH_DRAIN: begin
        if (imem_rvalid_i) state_next = FETCH_IDLE;
      end
      default: state_next = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= FETCH_IDLE;
      pc_q  <= '0;
    end else begin
      state <= state_next;
      if (accept) pc_q <= pc_i;
    end
  end

  inst_fifo #(
    .DEPTH (DEPTH)
  ) u_inst_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (push),
    .wr_pc     (pc_q),
    .wr_inst   (imem_rdata_i),
    .pop       (pop),
    .flush     (flush_i),
    .full      (full),
    .empty     (empty),
    .head_pc   (head_pc),
    .head_inst (head_inst)
  );

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetch
//  Description : Self-checking bench for inst_fetch: directed scenarios plus
//                randomized traffic against an in-order scoreboard and a
//                single-outstanding memory model.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;
  import cpu_pkg::*;

  localparam int DEPTH = FETCH_DEPTH;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic        pc_ready_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        flush_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;

  always #5 clk = ~clk;

  inst_fetch #(.DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .pc_i          (pc_i),
    .pc_valid_i    (pc_valid_i),
    .pc_ready_o    (pc_ready_o),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .flush_i       (flush_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .inst_ready_i  (inst_ready_i)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int delivered = 0;

  // Scoreboard: PCs accepted and not yet consumed or flushed, in order.
  logic [31:0] q[$];
  // Memory model: at most one granted read in flight.
  bit          mbusy;
  int          mlat;
  logic [31:0] maddr;
  bit          p_req, p_gnt, p_flush;
  logic [31:0] p_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0001;
  endfunction

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; pc_valid_i = 1'b1; pc_i = 32'h1234; flush_i = 1'b0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0; inst_ready_i = 1'b0;
    nxt(); nxt(); #1;
    check("rst_inst_valid", 32'(inst_valid_o), 0);
    check("rst_inst", inst_o, 0);
    check("rst_inst_pc", inst_pc_o, 0);
    check("rst_req", 32'(imem_req_o), 0);
    check("rst_addr", imem_addr_o, 0);
    check("rst_pc_ready", 32'(pc_ready_o), 0);
    nxt();
    rst_i = 1'b0; pc_valid_i = 1'b0;
    q.delete(); mbusy = 0; mlat = 0; p_req = 0; p_gnt = 0; p_flush = 0; p_addr = '0;
  endtask

  // Fetch one PC with immediate grant and one-cycle read latency.
  task automatic fetch_one(input logic [31:0] pc, input logic [31:0] data);
    pc_i = pc; pc_valid_i = 1'b1; #1;
    check("fetch_accept", 32'(pc_ready_o), 1);
    nxt(); pc_valid_i = 1'b0; imem_gnt_i = 1'b1;
    check("fetch_req", 32'(imem_req_o), 1);
    check("fetch_addr", imem_addr_o, pc);
    nxt(); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = data;
    nxt(); imem_rvalid_i = 1'b0;
  endtask

  task automatic rand_cycle(input bit traffic);
    flush_i      = traffic && ($urandom_range(0, 24) == 0);
    inst_ready_i = !traffic || ($urandom_range(0, 2) != 0);
    pc_valid_i   = traffic && ($urandom_range(0, 3) != 0);
    pc_i         = $urandom;
    imem_gnt_i   = imem_req_o && !mbusy && ($urandom_range(0, 2) == 0);
    if (mbusy && mlat == 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(maddr);
    end else begin
      // Stray responses while nothing is outstanding must be ignored.
      imem_rvalid_i = !mbusy && ($urandom_range(0, 7) == 0);
      imem_rdata_i  = 32'hBAD00000 | ($urandom & 32'hFFFF);
    end
    #1;
    if (p_req && !p_gnt && !p_flush) begin
      check("req_hold", 32'(imem_req_o), 1);
      check("addr_hold", imem_addr_o, p_addr);
    end
    if (imem_req_o) check("one_outstanding", 32'(mbusy), 0);
    if (flush_i) check("rdy_in_flush", 32'(pc_ready_o), 0);
    if (pc_ready_o) check("rdy_room", 32'(q.size() < DEPTH), 1);
    if (inst_valid_o && inst_ready_i && !flush_i) begin
      check("pop_expected", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        check("pop_pc", inst_pc_o, q[0]);
        check("pop_inst", inst_o, mem_word(q[0]));
        void'(q.pop_front());
        delivered++;
      end
    end
    if (flush_i) q.delete();
    else if (pc_valid_i && pc_ready_o) q.push_back(pc_i);
    if (imem_gnt_i && imem_req_o) begin
      mbusy = 1; maddr = imem_addr_o; mlat = $urandom_range(0, 3);
    end else if (mbusy) begin
      if (mlat == 0) mbusy = 0;
      else mlat--;
    end
    p_req = imem_req_o; p_gnt = imem_gnt_i; p_flush = flush_i; p_addr = imem_addr_o;
    nxt();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nxt();

    // First fetch: data visible three cycles after accept.
    do_reset();
    pc_i = 32'h0; pc_valid_i = 1'b1; #1;
    check("t1_accept", 32'(pc_ready_o), 1);
    nxt(); pc_valid_i = 1'b0; imem_gnt_i = 1'b1;
    check("t1_req", 32'(imem_req_o), 1);
    check("t1_addr", imem_addr_o, 32'h0);
    nxt(); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h8C010004;
    check("t1_req_dropped", 32'(imem_req_o), 0);
    check("t1_not_yet_valid", 32'(inst_valid_o), 0);
    nxt(); imem_rvalid_i = 1'b0;
    check("t1_valid", 32'(inst_valid_o), 1);
    check("t1_inst", inst_o, 32'h8C010004);
    check("t1_pc", inst_pc_o, 32'h0);

    // Buffer fills with decode stalled; one pop reopens pc_ready.
    fetch_one(32'h1, mem_word(32'h1));
    pc_i = 32'h2; pc_valid_i = 1'b1; #1;
    check("t2_full_rdy", 32'(pc_ready_o), 0);
    check("t2_hold_pc", inst_pc_o, 32'h0);
    check("t2_hold_inst", inst_o, 32'h8C010004);
    inst_ready_i = 1'b1;
    nxt(); inst_ready_i = 1'b0; pc_valid_i = 1'b0; #1;
    check("t2_head_pc", inst_pc_o, 32'h1);
    check("t2_head_inst", inst_o, mem_word(32'h1));
    check("t2_rdy_again", 32'(pc_ready_o), 1);

    // Grant held off four cycles: request and address stay stable.
    do_reset();
    pc_i = 32'h10; pc_valid_i = 1'b1; #1;
    check("t3_accept", 32'(pc_ready_o), 1);
    nxt(); pc_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      imem_gnt_i = (i == 4); #1;
      check("t3_hold_req", 32'(imem_req_o), 1);
      check("t3_hold_addr", imem_addr_o, 32'h10);
      nxt();
    end
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = mem_word(32'h10);
    nxt(); imem_rvalid_i = 1'b0;
    check("t3_valid", 32'(inst_valid_o), 1);
    check("t3_pc", inst_pc_o, 32'h10);
    check("t3_inst", inst_o, mem_word(32'h10));

    // Flush while waiting: late response discarded, next PC works.
    do_reset();
    pc_i = 32'h20; pc_valid_i = 1'b1;
    nxt(); pc_valid_i = 1'b0; imem_gnt_i = 1'b1;
    nxt(); imem_gnt_i = 1'b0; flush_i = 1'b1; #1;
    check("t4_rdy_flush", 32'(pc_ready_o), 0);
    nxt(); flush_i = 1'b0; #1;
    check("t4_drain_rdy", 32'(pc_ready_o), 0);
    check("t4_drain_valid", 32'(inst_valid_o), 0);
    nxt(); imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEADBEEF; #1;
    check("t4_drain_rdy2", 32'(pc_ready_o), 0);
    nxt(); imem_rvalid_i = 1'b0; #1;
    check("t4_discarded", 32'(inst_valid_o), 0);
    check("t4_idle_rdy", 32'(pc_ready_o), 1);
    fetch_one(32'h40, mem_word(32'h40));
    check("t4_valid", 32'(inst_valid_o), 1);
    check("t4_pc", inst_pc_o, 32'h40);
    check("t4_inst", inst_o, mem_word(32'h40));

    // Flush with a full buffer and a same-cycle pop.
    do_reset();
    fetch_one(32'h60, mem_word(32'h60));
    fetch_one(32'h64, mem_word(32'h64));
    flush_i = 1'b1; inst_ready_i = 1'b1;
    nxt(); flush_i = 1'b0; inst_ready_i = 1'b0; #1;
    check("t5_empty", 32'(inst_valid_o), 0);
    fetch_one(32'h80, mem_word(32'h80));
    check("t5_head_pc", inst_pc_o, 32'h80);
    check("t5_head_inst", inst_o, mem_word(32'h80));
    fetch_one(32'h84, mem_word(32'h84));
    check("t5_still_head", inst_pc_o, 32'h80);

    // Reset pulse while waiting for data.
    do_reset();
    pc_i = 32'h8; pc_valid_i = 1'b1;
    nxt(); pc_valid_i = 1'b0; imem_gnt_i = 1'b1;
    nxt(); imem_gnt_i = 1'b0; rst_i = 1'b1;
    nxt(); rst_i = 1'b0;
    check("t6_valid", 32'(inst_valid_o), 0);
    check("t6_inst", inst_o, 0);
    check("t6_inst_pc", inst_pc_o, 0);
    check("t6_req", 32'(imem_req_o), 0);
    check("t6_addr", imem_addr_o, 0);
    fetch_one(32'h4, mem_word(32'h4));
    check("t6_pc", inst_pc_o, 32'h4);
    check("t6_inst_ok", inst_o, mem_word(32'h4));

    // Randomized traffic against the scoreboard, then drain.
    do_reset();
    for (int i = 0; i < 3000; i++) rand_cycle(1'b1);
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0 && !mbusy && !imem_req_o) break;
      rand_cycle(1'b0);
    end
    check("drain_empty", 32'(q.size()), 0);
    check("progress", 32'(delivered > 100), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter DEPTH, 2, number of fetched-instruction buffer entries (2..8, power of two) SHALL be supported.
REQ-002 clk_i  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_i  input  1  reset; synchronous, active-high.
REQ-004 pc_i  input  32  word address of next instruction, driven by the PC stage.
REQ-005 pc_valid_i  input  1  pc_i is valid this cycle.
REQ-006 pc_ready_o  output  1  block accepts pc_i this cycle; transfer occurs when pc_valid_i & pc_ready_o.
REQ-007 imem_req_o  output  1  instruction-memory read request.
REQ-008 imem_addr_o  output  32  word address of the request.
REQ-009 imem_gnt_i  input  1  memory accepts request this cycle.
REQ-010 imem_rvalid_i  input  1  read data valid, one or more cycles after grant.
REQ-011 imem_rdata_i  input  32  instruction word.
REQ-012 flush_i  input  1  branch taken; discard all buffered and in-flight fetches.
REQ-013 inst_valid_o  output  1  head buffer entry valid toward decode.
REQ-014 inst_o  output  32  head instruction.
REQ-015 inst_pc_o  output  32  PC of head instruction.
REQ-016 inst_ready_i  input  1  decode consumes head this cycle (0 = stall).

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, DRAIN; at most one memory request outstanding.
REQ-018 pc_ready_o SHALL be 1 only in IDLE, with flush_i=0, rst_i=0, and buffer occupancy < DEPTH.
REQ-019 PC accepted in cycle N: pc registered; state REQ and imem_req_o=1, imem_addr_o=pc from cycle N+1.
REQ-020 In REQ, imem_req_o and imem_addr_o SHALL hold stable until imem_gnt_i=1; grant in cycle M -> WAIT from M+1, imem_req_o=0.
REQ-021 In WAIT, imem_rvalid_i=1 in cycle K SHALL write {pc, imem_rdata_i} to buffer tail; inst_valid_o=1 from K+1 if buffer was empty; state IDLE from K+1.
REQ-022 imem_rvalid_i outside WAIT/DRAIN SHALL be ignored.
REQ-023 Buffer SHALL be FIFO: inst_o/inst_pc_o show head; pop when inst_valid_o & inst_ready_i.
REQ-024 Push and pop in the same cycle SHALL both occur, occupancy unchanged; push never occurs when full (guaranteed by REQ-018).
REQ-025 inst_o, inst_pc_o SHALL hold stable while inst_valid_o=1 and inst_ready_i=0.
REQ-026 Pointers SHALL wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-027 flush_i=1 SHALL empty buffer next cycle (inst_valid_o=0) and override any same-cycle push or pop.
REQ-028 Flush in IDLE or REQ -> IDLE next cycle, imem_req_o=0 (ungranted request withdrawn, even if imem_gnt_i=1 that cycle -> treat as granted, go DRAIN).
REQ-029 Flush in WAIT -> DRAIN; in DRAIN the response SHALL be discarded on imem_rvalid_i, then IDLE.
REQ-030 Flush in WAIT coinciding with imem_rvalid_i -> response discarded, IDLE next cycle.
REQ-031 pc_ready_o SHALL be 0 in DRAIN; repeated flush in DRAIN keeps DRAIN.

Reset
REQ-032 rst_i=1 at a clock edge SHALL force IDLE, occupancy 0, pointers 0, regardless of in-flight request.
REQ-033 During and after reset: inst_valid_o=0, inst_o=0, inst_pc_o=0, imem_req_o=0, imem_addr_o=0, pc_ready_o=0 while rst_i=1.
REQ-034 A response arriving after reset for a pre-reset request is not supported; the memory SHALL be reset together with this block.

Structure
REQ-035 Shared package cpu_pkg SHALL hold the fetch state enum, ADDR_W=32, INST_W=32, and FETCH_DEPTH default.
REQ-036 The buffer SHALL be a sub-module inst_fifo (push, pop, flush, full, empty, head data); FSM stays in inst_fetch.

Verification
REQ-037 Reset, pc_i=0x00000000 valid, gnt same cycle as req, rvalid one cycle later with 0x8C010004 -> inst_valid_o=1, inst_o=0x8C010004, inst_pc_o=0 three cycles after PC accept.
REQ-038 inst_ready_i=0, PCs 0,1 fetched -> occupancy 2, pc_ready_o=0 with pc_valid_i=1; inst_ready_i=1 one cycle -> head becomes PC 1, pc_ready_o=1 next cycle.
REQ-039 Grant held off 4 cycles with pc 0x10 -> imem_req_o=1, imem_addr_o=0x10 stable all 5 cycles.
REQ-040 Flush in WAIT (pc 0x20), rvalid 2 cycles later with 0xDEADBEEF -> never appears on inst_o; next PC 0x40 fetched and delivered normally.
REQ-041 Flush with buffer full and inst_ready_i=1 same cycle -> inst_valid_o=0 next cycle, occupancy 0.
REQ-042 rst_i pulsed in WAIT -> all outputs per REQ-033 next cycle; subsequent fetch of pc 0x4 delivers correct data.
